n1_mem_arbiter: RTL and testbench

Shares the n1 program/data RAM port between three requesters: host loader (H), core data port (D) and core instruction fetch (F). It issues at most one access per cycle into the single registered RAM port and routes read data back to the requester that owns it. Pipelined with one grant per cycle, 2-cycle read latency, no bubbles between back-to-back accesses. Sits between the host pin decoder / n1 core and the two-RAM block.

---
 rtl/n1_mem_pkg.sv | 24 ++
 rtl/n1_arb_pick.sv | 36 +++
 rtl/n1_mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_n1_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/n1_mem_pkg.sv
// Shared constants and types for the n1 RAM-port arbiter: default widths,
// RAM select encodings, read-owner tags and one-hot grant codes.
package n1_mem_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 8;

  localparam logic SEL_PROG = 1'b0;
  localparam logic SEL_DATA = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_HOST   = 2'd1,
    OWN_CORE_D = 2'd2,
    OWN_CORE_F = 2'd3
  } owner_e;

  // One-hot grant vector layout: {F, D, H}
  localparam logic [2:0] GNT_NONE = 3'b000;
  localparam logic [2:0] GNT_H    = 3'b001;
  localparam logic [2:0] GNT_D    = 3'b010;
  localparam logic [2:0] GNT_F    = 3'b100;

endpackage

// File: rtl/n1_arb_pick.sv
// Combinational grant selection: host priority with starvation override,
// round-robin between core data and fetch ports. Produces a one-hot grant.
module n1_arb_pick
  import n1_mem_pkg::*;
(
  input  logic       host_req,
  input  logic       d_req,
  input  logic       f_req,
  input  logic       host_lock,
  input  logic       starve_at_limit,
  input  logic       rr_prefer_f,
  output logic [2:0] gnt
);

  logic core_pending;
  logic core_ok;

  assign core_pending = d_req | f_req;
  assign core_ok      = !host_lock;

  always_comb begin
    gnt = GNT_NONE;
    if (host_req && !(starve_at_limit && core_pending && core_ok)) begin
      gnt = GNT_H;
    end else if (core_ok) begin
      if (d_req && f_req) begin
        gnt = rr_prefer_f ? GNT_F : GNT_D;
      end else if (d_req) begin
        gnt = GNT_D;
      end else if (f_req) begin
        gnt = GNT_F;
      end
    end
  end

endmodule

// File: rtl/n1_mem_arbiter.sv
// Three-way arbiter for the shared n1 program/data RAM port with 2-cycle read
// return. Optional perf counters enabled by defining N1_ARB_PERF_EN.
module n1_mem_arbiter
  import n1_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              host_req,
  input  logic              host_we,
  input  logic              host_sel,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,

  input  logic              core_d_req,
  input  logic              core_d_we,
  input  logic [ADDR_W-1:0] core_d_addr,
  input  logic [DATA_W-1:0] core_d_wdata,
  output logic              core_d_gnt,
  output logic              core_d_rvalid,
  output logic [DATA_W-1:0] core_d_rdata,

  input  logic              core_f_req,
  input  logic [ADDR_W-1:0] core_f_addr,
  output logic              core_f_gnt,
  output logic              core_f_rvalid,
  output logic [DATA_W-1:0] core_f_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic [15:0]       perf_host_grants,
  output logic [15:0]       perf_core_grants,
  output logic [15:0]       perf_core_stall
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_at_limit;
  logic             rr_prefer_f;
  logic [2:0]       gnt;
  logic             any_gnt;
  logic             core_gnt_any;
  logic             core_pending;

  // Grants are suppressed while in reset so nothing is accepted then.
  n1_arb_pick u_pick (
    .host_req        (host_req   & ~rst),
    .d_req           (core_d_req & ~rst),
    .f_req           (core_f_req & ~rst),
    .host_lock       (host_lock),
    .starve_at_limit (starve_at_limit),
    .rr_prefer_f     (rr_prefer_f),
    .gnt             (gnt)
  );

  assign host_gnt        = gnt[0];
  assign core_d_gnt      = gnt[1];
  assign core_f_gnt      = gnt[2];
  assign any_gnt         = |gnt;
  assign core_gnt_any    = gnt[1] | gnt[2];
  assign core_pending    = (core_d_req | core_f_req) & ~rst;
  assign starve_at_limit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt  <= '0;
      rr_prefer_f <= 1'b0;
    end else begin
      if (host_lock || !core_pending || core_gnt_any) begin
        starve_cnt <= '0;
      end else if (host_gnt && !starve_at_limit) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
      if (gnt[1]) begin
        rr_prefer_f <= 1'b1;
      end else if (gnt[2]) begin
        rr_prefer_f <= 1'b0;
      end
    end
  end

  // ---- stage p0: select the granted request's fields ----
  logic              we_p0;
  logic              sel_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  owner_e            own_p0;

  always_comb begin
    we_p0    = 1'b0;
    sel_p0   = mem_sel;
    addr_p0  = mem_addr;
    wdata_p0 = mem_wdata;
    own_p0   = OWN_NONE;
    unique case (gnt)
      GNT_H: begin
        we_p0    = host_we;
        sel_p0   = host_sel;
        addr_p0  = host_addr;
        wdata_p0 = host_wdata;
        own_p0   = OWN_HOST;
      end
      GNT_D: begin
        we_p0    = core_d_we;
        sel_p0   = SEL_DATA;
        addr_p0  = core_d_addr;
        wdata_p0 = core_d_wdata;
        own_p0   = OWN_CORE_D;
      end
      GNT_F: begin
        we_p0    = 1'b0;
        sel_p0   = SEL_PROG;
        addr_p0  = core_f_addr;
        own_p0   = OWN_CORE_F;
      end
      default: ;
    endcase
  end

  // ---- stage p1: registered RAM strobe and read-owner tag ----
  owner_e tag_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tag_p1    <= OWN_NONE;
    end else begin
      mem_en <= any_gnt;
      tag_p1 <= (any_gnt && !we_p0) ? own_p0 : OWN_NONE;
      if (any_gnt) begin
        mem_we    <= we_p0;
        mem_sel   <= sel_p0;
        mem_addr  <= addr_p0;
        mem_wdata <= wdata_p0;
      end
    end
  end

  // ---- stage p2: owner read-valid, data returned from RAM ----
  logic              vld_p2_h;
  logic              vld_p2_d;
  logic              vld_p2_f;
  logic [DATA_W-1:0] host_rdata_q;
  logic [DATA_W-1:0] core_d_rdata_q;
  logic [DATA_W-1:0] core_f_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_h       <= 1'b0;
      vld_p2_d       <= 1'b0;
      vld_p2_f       <= 1'b0;
      host_rdata_q   <= '0;
      core_d_rdata_q <= '0;
      core_f_rdata_q <= '0;
    end else begin
      vld_p2_h <= (tag_p1 == OWN_HOST);
      vld_p2_d <= (tag_p1 == OWN_CORE_D);
      vld_p2_f <= (tag_p1 == OWN_CORE_F);
      if (vld_p2_h) host_rdata_q   <= mem_rdata;
      if (vld_p2_d) core_d_rdata_q <= mem_rdata;
      if (vld_p2_f) core_f_rdata_q <= mem_rdata;
    end
  end

  // RAM data lands in the valid cycle itself; the _q copy keeps it afterwards.
  assign host_rvalid   = vld_p2_h;
  assign core_d_rvalid = vld_p2_d;
  assign core_f_rvalid = vld_p2_f;
  assign host_rdata    = vld_p2_h ? mem_rdata : host_rdata_q;
  assign core_d_rdata  = vld_p2_d ? mem_rdata : core_d_rdata_q;
  assign core_f_rdata  = vld_p2_f ? mem_rdata : core_f_rdata_q;

`ifdef N1_ARB_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_host_grants <= '0;
      perf_core_grants <= '0;
      perf_core_stall  <= '0;
    end else begin
      if (host_gnt)                      perf_host_grants <= sat_inc16(perf_host_grants);
      if (core_gnt_any)                  perf_core_grants <= sat_inc16(perf_core_grants);
      if (core_pending && !core_gnt_any) perf_core_stall  <= sat_inc16(perf_core_stall);
    end
  end
`else
  assign perf_host_grants = '0;
  assign perf_core_grants = '0;
  assign perf_core_stall  = '0;
`endif

endmodule

// File: tb/tb_n1_mem_arbiter.sv
// Directed bench for n1_mem_arbiter with a behavioural two-RAM model and a
// read-response scoreboard checked by an independent monitor.
module tb_n1_mem_arbiter;
  import n1_mem_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_req = 0, host_we = 0, host_sel = 0, host_lock = 0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          core_d_req = 0, core_d_we = 0;
  logic [AW-1:0] core_d_addr = '0;
  logic [DW-1:0] core_d_wdata = '0;
  logic          core_d_gnt, core_d_rvalid;
  logic [DW-1:0] core_d_rdata;
  logic          core_f_req = 0;
  logic [AW-1:0] core_f_addr = '0;
  logic          core_f_gnt, core_f_rvalid;
  logic [DW-1:0] core_f_rdata;
  logic          mem_en, mem_we, mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   perf_host_grants, perf_core_grants, perf_core_stall;

  n1_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_lock(host_lock),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .core_d_req(core_d_req), .core_d_we(core_d_we), .core_d_addr(core_d_addr),
    .core_d_wdata(core_d_wdata), .core_d_gnt(core_d_gnt),
    .core_d_rvalid(core_d_rvalid), .core_d_rdata(core_d_rdata),
    .core_f_req(core_f_req), .core_f_addr(core_f_addr), .core_f_gnt(core_f_gnt),
    .core_f_rvalid(core_f_rvalid), .core_f_rdata(core_f_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_host_grants(perf_host_grants), .perf_core_grants(perf_core_grants),
    .perf_core_stall(perf_core_stall)
  );

  always #5 clk = ~clk;

  // Behavioural RAMs: registered read, data one cycle after the strobe.
  logic [DW-1:0] prog_ram [0:63];
  logic [DW-1:0] data_ram [0:63];
  initial begin
    for (int i = 0; i < 64; i++) begin
      prog_ram[i] = '0;
      data_ram[i] = '0;
    end
    prog_ram[30] = 8'h5A;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        if (mem_sel) data_ram[mem_addr] = mem_wdata;
        else         prog_ram[mem_addr] = mem_wdata;
      end else begin
        mem_rdata <= mem_sel ? data_ram[mem_addr] : prog_ram[mem_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    owner_e        own;
    logic [DW-1:0] data;
    int            at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_resp(input owner_e o, input logic [DW-1:0] d);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL rvalid_unexpected: owner %0d data %0h with nothing outstanding (cycle %0d)", o, d, cyc);
    end else begin
      e = sb.pop_front();
      if (e.own != o || e.data !== d || e.at != cyc) begin
        failures++;
        $display("FAIL rvalid_resp: got owner %0d data %0h cycle %0d, expected owner %0d data %0h cycle %0d",
                 o, d, cyc, e.own, e.data, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (host_rvalid)   check_resp(OWN_HOST, host_rdata);
    if (core_d_rvalid) check_resp(OWN_CORE_D, core_d_rdata);
    if (core_f_rvalid) check_resp(OWN_CORE_F, core_f_rdata);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all;
    host_req = 0; core_d_req = 0; core_f_req = 0;
  endtask

  function automatic logic [2:0] gvec();
    return {core_f_gnt, core_d_gnt, host_gnt};
  endfunction

  logic [2:0] gseq [0:14];

  initial begin
    gseq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010,
             3'b001, 3'b001, 3'b001, 3'b001, 3'b100,
             3'b001, 3'b001, 3'b001, 3'b001, 3'b010};

    // Reset with every request asserted
    rst = 1;
    host_req = 1; host_we = 1; host_sel = 0; host_addr = 6'd0; host_wdata = 8'h00;
    core_d_req = 1; core_d_we = 1; core_d_addr = 6'd0; core_d_wdata = 8'h00;
    core_f_req = 1; core_f_addr = 6'd0;
    tick; tick;
    @(negedge clk);
    chk("rst_gnt", {29'd0, gvec()}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_fields", {14'd0, mem_we, mem_sel, mem_addr, mem_wdata}, 32'd0);
    chk("rst_rvalid", {29'd0, host_rvalid, core_d_rvalid, core_f_rvalid}, 32'd0);
    chk("rst_rdata", {8'd0, host_rdata, core_d_rdata, core_f_rdata}, 32'd0);
    tick;
    rst = 0;
    @(negedge clk);
    chk("post_rst_gnt", {29'd0, gvec()}, {29'd0, GNT_H});
    tick;
    drop_all;
    tick; tick; tick;

    // Host write prog[3]=A5, then fetch read of addr 3
    host_req = 1; host_we = 1; host_sel = SEL_PROG; host_addr = 6'd3; host_wdata = 8'hA5;
    core_f_req = 1; core_f_addr = 6'd3;
    @(negedge clk);
    chk("hw_then_f_gnt0", {29'd0, gvec()}, {29'd0, GNT_H});
    tick;
    host_req = 0;
    @(negedge clk);
    chk("hw_then_f_gnt1", {29'd0, gvec()}, {29'd0, GNT_F});
    sb.push_back('{own: OWN_CORE_F, data: 8'hA5, at: cyc + 2});
    tick;
    drop_all;
    for (int i = 0; i < 4; i++) tick;
    @(negedge clk);
    chk("f_rdata_hold", {24'd0, core_f_rdata}, 32'h0000_00A5);
    tick;

    // All three requesting continuously: starvation limit and D/F round-robin
    host_req = 1; host_we = 1; host_sel = SEL_DATA; host_addr = 6'd10; host_wdata = 8'h11;
    core_d_req = 1; core_d_we = 1; core_d_addr = 6'd20; core_d_wdata = 8'h22;
    core_f_req = 1; core_f_addr = 6'd30;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("starve_seq%0d", i), {29'd0, gvec()}, {29'd0, gseq[i]});
      if (gseq[i] == GNT_F) sb.push_back('{own: OWN_CORE_F, data: 8'h5A, at: cyc + 2});
      tick;
    end
    drop_all;
    tick; tick; tick;

    // Host lock holds off the core; releasing it grants the core at once
    host_lock = 1;
    core_d_req = 1; core_d_we = 1; core_d_addr = 6'd21; core_d_wdata = 8'h33;
    core_f_req = 1; core_f_addr = 6'd30;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("lock_no_gnt%0d", i), {29'd0, gvec()}, 32'd0);
      tick;
    end
    host_lock = 0;
    @(negedge clk);
    chk("unlock_gnt", {29'd0, gvec()}, {29'd0, GNT_F});
    sb.push_back('{own: OWN_CORE_F, data: 8'h5A, at: cyc + 2});
    tick;
    drop_all;
    tick; tick; tick;

    // Data write then immediate read of the same address, back to back
    core_d_req = 1; core_d_we = 1; core_d_addr = 6'd5; core_d_wdata = 8'h3C;
    @(negedge clk);
    chk("dwr_gnt", {29'd0, gvec()}, {29'd0, GNT_D});
    tick;
    core_d_we = 0;
    @(negedge clk);
    chk("drd_gnt", {29'd0, gvec()}, {29'd0, GNT_D});
    chk("dwr_mem", {29'd0, mem_en, mem_we, mem_sel}, 32'd7);
    sb.push_back('{own: OWN_CORE_D, data: 8'h3C, at: cyc + 2});
    tick;
    drop_all;
    @(negedge clk);
    chk("drd_mem", {21'd0, mem_en, mem_we, mem_sel, mem_addr}, {21'd0, 3'b101, 6'd5});
    tick;
    @(negedge clk);
    chk("dback_mem_en_low", {31'd0, mem_en}, 32'd0);
    tick; tick; tick;

    // Host read dropped by a reset in the following cycle
    host_req = 1; host_we = 0; host_sel = SEL_PROG; host_addr = 6'd3;
    @(negedge clk);
    chk("hrd_gnt", {29'd0, gvec()}, {29'd0, GNT_H});
    tick;
    host_req = 0;
    rst = 1;
    @(negedge clk);
    chk("hrd_mem_en", {31'd0, mem_en}, 32'd1);
    tick;
    rst = 0;
    @(negedge clk);
    chk("rst_drop_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_drop_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_clears_rdata", {16'd0, core_f_rdata, core_d_rdata}, 32'd0);
    for (int i = 0; i < 5; i++) tick;

    // Every scheduled read must have come back
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick;
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
